// File: rtl/rr_encoder_4to2_if.sv
// Request/selection bundle for the 4-to-2 round-robin encoder.
// master = encoder side, slave = requester/consumer side.
interface rr_encoder_4to2_if;
  logic [3:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] out_sel;
  logic [3:0] grant;

  modport master (
    input  req, out_ready,
    output out_valid, out_sel, grant
  );

  modport slave (
    output req, out_ready,
    input  out_valid, out_sel, grant
  );
endinterface

// File: rtl/rr_encoder_4to2.sv
// Round-robin 4-to-2 priority encoder with a valid/ready output stage.
// Every output comes straight from a flop; ptr remembers the last accepted index.
module rr_encoder_4to2 #(
  parameter bit LOCK = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  rr_encoder_4to2_if.master   bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       any_req;
  logic       sel_held;

  // First set bit scanning p+1, p+2, p+3, p: index p itself ranks last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + k[1:0];
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign any_req  = |bus.req;
  assign sel_held = bus.req[sel_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = HOLD;
          sel_d   = rr_pick(bus.req, ptr_q);
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          // Accept: arbitrate against the just-accepted index as the new pointer.
          ptr_d = sel_q;
          if (any_req) sel_d   = rr_pick(bus.req, sel_q);
          else         state_d = IDLE;
        end else if (!LOCK && !sel_held) begin
          if (any_req) sel_d   = rr_pick(bus.req, ptr_q);
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == HOLD) ? (4'b0001 << sel_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'b11;
      sel_q   <= 2'b00;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sel   = sel_q;
  assign bus.grant     = gnt_q;

endmodule

// File: tb/tb_rr_encoder_4to2.sv
// Bench for rr_encoder_4to2: LOCK=1 and LOCK=0 instances share stimulus and
// are compared every cycle against a round-robin reference model.
module tb_rr_encoder_4to2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_encoder_4to2_if b0 ();
  rr_encoder_4to2_if b1 ();

  rr_encoder_4to2 #(.LOCK(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  rr_encoder_4to2 #(.LOCK(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));

  int vectors = 0;
  int miscompares = 0;

  // Reference model, index 0 = LOCK=0 instance, 1 = LOCK=1 instance.
  bit       mv [2];
  int       ms [2];
  int       mp [2];
  int       waits [4];

  function automatic int pick(int p, logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_edge(int d, bit lock, logic [3:0] r, logic rdy);
    if (!mv[d]) begin
      if (r != 4'b0) begin mv[d] = 1'b1; ms[d] = pick(mp[d], r); end
    end else if (rdy) begin
      mp[d] = ms[d];
      if (r != 4'b0) ms[d] = pick(mp[d], r);
      else           mv[d] = 1'b0;
    end else if (!lock && !r[ms[d]]) begin
      if (r != 4'b0) ms[d] = pick(mp[d], r);
      else           mv[d] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin mv[d] = 1'b0; ms[d] = 0; mp[d] = 3; end
    for (int i = 0; i < 4; i++) waits[i] = 0;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [3:0] eg;
    eg = mv[0] ? (4'b0001 << ms[0]) : 4'b0000;
    check("l0_valid", b0.out_valid, mv[0]);
    check("l0_sel",   b0.out_sel,   ms[0]);
    check("l0_grant", b0.grant,     eg);
    eg = mv[1] ? (4'b0001 << ms[1]) : 4'b0000;
    check("l1_valid", b1.out_valid, mv[1]);
    check("l1_sel",   b1.out_sel,   ms[1]);
    check("l1_grant", b1.grant,     eg);
    if (b0.out_valid === 1'b1) check("l0_onehot", $countones(b0.grant), 1);
    if (b1.out_valid === 1'b1) check("l1_onehot", $countones(b1.grant), 1);
  endtask

  task automatic set_in(logic [3:0] r, logic rdy);
    b0.req = r; b1.req = r;
    b0.out_ready = rdy; b1.out_ready = rdy;
  endtask

  // One clock: capture pre-edge view, advance model, then sample 1 ns later.
  task automatic step();
    logic [3:0] r;
    logic       rdy, pv;
    logic [1:0] ps;
    r = b1.req; rdy = b1.out_ready; pv = b1.out_valid; ps = b1.out_sel;
    @(posedge clk);
    model_edge(0, 1'b0, r, rdy);
    model_edge(1, 1'b1, r, rdy);
    for (int i = 0; i < 4; i++) begin
      if (!r[i]) waits[i] = 0;
      else if (pv && rdy) begin
        if (ps == i[1:0]) waits[i] = 0;
        else begin
          waits[i]++;
          check("starve", (waits[i] <= 4), 1);
        end
      end
    end
    #1;
    check_model();
    if (pv && !rdy) begin
      check("lock_hold_valid", b1.out_valid, 1);
      check("lock_hold_sel",   b1.out_sel,   ps);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    set_in(4'b0000, 1'b0);
    model_reset();
    #1;
    check_model();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    logic [1:0] exp_seq [4];

    // Reset state and saturated requests with no consumer.
    reset = 1'b0;
    set_in(4'b0000, 1'b0);
    model_reset();
    #1;
    check("rst_valid", b1.out_valid, 0);
    check("rst_sel",   b1.out_sel,   0);
    check("rst_grant", b1.grant,     0);
    @(negedge clk);
    reset = 1'b1;
    set_in(4'b1111, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("all_req_sel",   b1.out_sel, 0);
      check("all_req_grant", b1.grant,   4'b0001);
    end

    // Continuous accept walks 1,2,3,0 with no bubble.
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0;
    set_in(4'b1111, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step();
      check("rr_seq_sel",   b1.out_sel,   exp_seq[c]);
      check("rr_seq_valid", b1.out_valid, 1);
    end

    // Sole requester is re-granted; then drop to idle.
    apply_reset();
    set_in(4'b0100, 1'b0); step();
    set_in(4'b0100, 1'b1); step();
    check("regrant_sel",   b1.out_sel,   2);
    check("regrant_valid", b1.out_valid, 1);
    set_in(4'b0000, 1'b1); step();
    check("idle_valid", b1.out_valid, 0);
    check("idle_grant", b1.grant,     0);
    set_in(4'b0000, 1'b1); step();
    check("idle_ignore_ready", b1.out_valid, 0);

    // Request withdrawal: LOCK=1 holds, LOCK=0 re-arbitrates.
    apply_reset();
    set_in(4'b0010, 1'b0); step();
    set_in(4'b1000, 1'b0);
    for (int c = 0; c < 2; c++) begin
      step();
      check("lock1_sel", b1.out_sel, 1);
      check("lock0_sel", b0.out_sel, 3);
    end
    set_in(4'b0011, 1'b1); step();
    check("lock0_after_accept", b0.out_sel, 0);
    set_in(4'b0000, 1'b0); step();
    check("lock0_drop_all", b0.out_valid, 0);

    // Asynchronous reset in HOLD, then release.
    apply_reset();
    set_in(4'b1000, 1'b0); step();
    check("pre_rst_sel", b1.out_sel, 3);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_valid", b1.out_valid, 0);
    check("async_sel",   b1.out_sel,   0);
    check("async_grant", b1.grant,     0);
    check_model();
    @(negedge clk);
    set_in(4'b1010, 1'b0);
    reset = 1'b1;
    #1;
    check("release_no_edge", b1.out_valid, 0);
    step();
    check("post_rst_sel", b1.out_sel, 1);
    check("post_rst_sel0", b0.out_sel, 1);

    // Random sticky requests, random ready.
    apply_reset();
    r = 4'($urandom_range(15));
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(3) == 0) r[i] = ~r[i];
      set_in(r, 1'($urandom_range(1)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
